// File: rtl/fish_pkg.sv
// Shared constants and default geometry for the fish sprite display path.
// Screen coordinates here are in the 320x240 scaled space.
package fish_pkg;

   localparam int SCR_W = 320;
   localparam int SCR_H = 240;

   localparam logic [11:0] KEY_COLOR = 12'h0F0;
   localparam logic [11:0] BG_COLOR  = 12'h048;

   localparam int DEF_FISH_W    = 64;
   localparam int DEF_FISH_H    = 32;
   localparam int DEF_FRAMES    = 8;
   localparam int DEF_FISH_Y    = 64;
   localparam int DEF_SPEED     = 1;
   localparam int DEF_FRAME_DIV = 4;

   // Half-open span test [lo, lo+len) in plain 10-bit unsigned math.
   function automatic logic in_span(
      input logic [9:0] v,
      input logic [9:0] lo,
      input int         len
   );
      logic [9:0] hi;
      hi = lo + 10'(len);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/fish_motion.sv
// Per-video-frame animation state: horizontal position and frame index.
// Everything advances only on a vsync falling edge.
module fish_motion
   import fish_pkg::*;
#(
   parameter int FRAMES    = DEF_FRAMES,
   parameter int SPEED     = DEF_SPEED,
   parameter int FRAME_DIV = DEF_FRAME_DIV,
   parameter int FI_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            vsync_i,
   output logic [8:0]      fish_x,
   output logic [FI_W-1:0] frame_idx
);

   localparam int DC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic            vsync_q;
   logic            vs_fall;
   logic [9:0]      x_sum;
   logic [DC_W-1:0] div_cnt;

   assign vs_fall = vsync_q & ~vsync_i;
   assign x_sum   = {1'b0, fish_x} + 10'(SPEED);

   // Registered vsync copy; idles high so reset never fakes an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vsync_q <= 1'b1;
      else       vsync_q <= vsync_i;
   end

   // Horizontal position, wrapping back past the right screen edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fish_x <= '0;
      end else if (vs_fall) begin
         if (x_sum >= 10'(SCR_W)) fish_x <= 9'(x_sum - 10'(SCR_W));
         else                     fish_x <= x_sum[8:0];
      end
   end

   // Frame divider and animation frame index, independent of fish_x.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt   <= '0;
         frame_idx <= '0;
      end else if (vs_fall) begin
         if (div_cnt == DC_W'(FRAME_DIV - 1)) begin
            div_cnt <= '0;
            if (frame_idx == FI_W'(FRAMES - 1)) frame_idx <= '0;
            else                                frame_idx <= frame_idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fish_pixel_fetch.sv
// Sprite SRAM address generation and 2-clk RGB/sync output pipeline.
// SRAM data is expected during the cycle after the address is registered.
module fish_pixel_fetch
   import fish_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 16,
   parameter int FISH_W     = DEF_FISH_W,
   parameter int FISH_H     = DEF_FISH_H,
   parameter int FRAMES     = DEF_FRAMES,
   parameter int FISH_Y     = DEF_FISH_Y,
   parameter int SPEED      = DEF_SPEED,
   parameter int FRAME_DIV  = DEF_FRAME_DIV
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  video_on,
   input  logic                  hsync_i,
   input  logic                  vsync_i,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_en,
   input  logic [DATA_WIDTH-1:0] sram_data,
   output logic [DATA_WIDTH-1:0] rgb,
   output logic                  hsync_o,
   output logic                  vsync_o
);

   localparam int FI_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   logic [8:0]            fish_x;
   logic [FI_W-1:0]       frame_idx;
   logic [9:0]            sx;
   logic [9:0]            sy;
   logic [9:0]            fx10;
   logic [9:0]            row;
   logic [9:0]            col;
   logic                  in_region;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic                  in_region_d1;
   logic                  video_on_d1;
   logic                  hsync_d1;
   logic                  vsync_d1;
   logic [DATA_WIDTH-1:0] pix_c;
   logic                  unused_lsb;

   fish_motion #(
      .FRAMES    (FRAMES),
      .SPEED     (SPEED),
      .FRAME_DIV (FRAME_DIV),
      .FI_W      (FI_W)
   ) u_motion (
      .clk       (clk),
      .reset     (reset),
      .vsync_i   (vsync_i),
      .fish_x    (fish_x),
      .frame_idx (frame_idx)
   );

   assign sx         = {1'b0, pixel_x[9:1]};
   assign sy         = {1'b0, pixel_y[9:1]};
   assign unused_lsb = pixel_x[0] ^ pixel_y[0];
   assign fx10       = {1'b0, fish_x};
   assign row        = sy - 10'(FISH_Y);
   assign col        = sx - fx10;

   assign in_region = video_on
                    & in_span(sx, fx10, FISH_W)
                    & in_span(sy, 10'(FISH_Y), FISH_H);

   // Sprite word address: frame base + row stride + column.
   always_comb begin
      addr_c = '0;
      if (in_region) begin
         addr_c = ADDR_WIDTH'(frame_idx) * ADDR_WIDTH'(FISH_W * FISH_H)
                + ADDR_WIDTH'(row) * ADDR_WIDTH'(FISH_W)
                + ADDR_WIDTH'(col);
      end
   end

   // Stage 1: SRAM request plus the flags that travel with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_addr    <= '0;
         sram_en      <= 1'b0;
         in_region_d1 <= 1'b0;
         video_on_d1  <= 1'b0;
         hsync_d1     <= 1'b1;
         vsync_d1     <= 1'b1;
      end else begin
         sram_addr    <= addr_c;
         sram_en      <= in_region;
         in_region_d1 <= in_region;
         video_on_d1  <= video_on;
         hsync_d1     <= hsync_i;
         vsync_d1     <= vsync_i;
      end
   end

   // Colour select: blank, background/chroma key, or sprite word.
   always_comb begin
      pix_c = '0;
      if (video_on_d1) begin
         if (!in_region_d1 || sram_data == DATA_WIDTH'(KEY_COLOR))
            pix_c = DATA_WIDTH'(BG_COLOR);
         else
            pix_c = sram_data;
      end
   end

   // Stage 2: registered pins, syncs kept aligned with colour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb     <= '0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         rgb     <= pix_c;
         hsync_o <= hsync_d1;
         vsync_o <= vsync_d1;
      end
   end

endmodule

// File: tb/tb_fish_pixel_fetch.sv
// Randomised scoreboard bench for fish_pixel_fetch.
// A screen-level model predicts address, colour, syncs and motion.
module tb_fish_pixel_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic        video_on = 1'b0;
   logic        hsync_i = 1'b1;
   logic        vsync_i = 1'b1;
   logic [15:0] sram_addr;
   logic        sram_en;
   logic [11:0] sram_data;
   logic [11:0] rgb;
   logic        hsync_o;
   logic        vsync_o;

   logic [11:0] mem [65536];

   int checks = 0;
   int failures = 0;

   // Model state
   int m_fx = 0;
   int m_fi = 0;
   int m_div = 0;
   logic m_prev_vs = 1'b1;

   typedef struct {
      int   addr;
      logic en;
      int   rgb;
      logic hs;
      logic vs;
      int   fx;
      int   fi;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   fish_pixel_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .video_on  (video_on),
      .hsync_i   (hsync_i),
      .vsync_i   (vsync_i),
      .sram_addr (sram_addr),
      .sram_en   (sram_en),
      .sram_data (sram_data),
      .rgb       (rgb),
      .hsync_o   (hsync_o),
      .vsync_o   (vsync_o)
   );

   always #5 clk = ~clk;

   assign sram_data = mem[sram_addr];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int px, input int py,
                        input logic vo, input logic hs, input logic vs);
      exp_t e;
      int sx, sy, a;
      logic inr;
      @(negedge clk);
      pixel_x  = 10'(px);
      pixel_y  = 10'(py);
      video_on = vo;
      hsync_i  = hs;
      vsync_i  = vs;
      sx = px / 2;
      sy = py / 2;
      inr = vo && sx >= m_fx && sx < m_fx + 64 && sy >= 64 && sy < 96;
      a = inr ? m_fi * 2048 + (sy - 64) * 64 + (sx - m_fx) : 0;
      e.addr = a;
      e.en   = inr;
      e.hs   = hs;
      e.vs   = vs;
      if (!vo)                            e.rgb = 0;
      else if (!inr || mem[a] == 12'h0F0) e.rgb = 'h048;
      else                                e.rgb = int'(mem[a]);
      if (m_prev_vs && !vs) begin
         m_fx = (m_fx + 1) % 320;
         m_div++;
         if (m_div == 4) begin
            m_div = 0;
            m_fi = (m_fi + 1) % 8;
         end
      end
      m_prev_vs = vs;
      e.fx = m_fx;
      e.fi = m_fi;
      q1.push_back(e);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset    = 1'b1;
      video_on = 1'b0;
      hsync_i  = 1'b1;
      vsync_i  = 1'b1;
      q1.delete();
      q2.delete();
      #1;
      chk("rst_now_rgb", int'(rgb), 0);
      chk("rst_now_en", int'(sram_en), 0);
      chk("rst_now_hs", int'(hsync_o), 1);
      m_fx = 0;
      m_fi = 0;
      m_div = 0;
      m_prev_vs = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rnd_pix(input logic vo);
      int s, px, py;
      if ($urandom_range(0, 1) == 0) begin
         px = int'($urandom_range(0, 639));
         py = int'($urandom_range(0, 479));
      end else begin
         s = m_fx + int'($urandom_range(0, 72)) - 4;
         if (s < 0) s = 0;
         if (s > 319) s = 319;
         px = s * 2 + int'($urandom_range(0, 1));
         py = int'($urandom_range(120, 200));
      end
      drive(px, py, vo, 1'($urandom_range(0, 1)), 1'b1);
   endtask

   task automatic vs_pulse();
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: stage-1 outputs one clk after input, stage-2 one clk later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            chk("rst_rgb", int'(rgb), 0);
            chk("rst_hs", int'(hsync_o), 1);
            chk("rst_vs", int'(vsync_o), 1);
            chk("rst_en", int'(sram_en), 0);
            chk("rst_addr", int'(sram_addr), 0);
            chk("rst_fx", int'(dut.fish_x), 0);
            chk("rst_fi", int'(dut.frame_idx), 0);
         end else begin
            if (q2.size() > 0) begin
               e = q2.pop_front();
               chk("rgb", int'(rgb), e.rgb);
               chk("hsync_o", int'(hsync_o), int'(e.hs));
               chk("vsync_o", int'(vsync_o), int'(e.vs));
            end
            if (q1.size() > 0) begin
               e = q1.pop_front();
               chk("sram_addr", int'(sram_addr), e.addr);
               chk("sram_en", int'(sram_en), int'(e.en));
               chk("fish_x", int'(dut.fish_x), e.fx);
               chk("frame_idx", int'(dut.frame_idx), e.fi);
               q2.push_back(e);
            end
         end
      end
   end

   initial begin
      int guard;
      for (int i = 0; i < 65536; i++) begin
         if ($urandom_range(0, 7) == 0) mem[i] = 12'h0F0;
         else                           mem[i] = 12'($urandom);
      end
      mem[69] = 12'hF80;
      mem[70] = 12'h0F0;

      do_reset(5);

      // Directed: sx=5, sy=65 -> 69; sx=6 -> keyed word
      drive(10, 130, 1'b1, 1'b1, 1'b1);
      drive(12, 130, 1'b1, 1'b0, 1'b1);
      drive(11, 131, 1'b1, 1'b1, 1'b1);

      repeat (200) rnd_pix(1'b1);

      // Motion: 330 edges spans the fish_x and frame_idx wraps
      for (int i = 0; i < 330; i++) begin
         vs_pulse();
         repeat (4) rnd_pix(1'b1);
      end

      guard = 0;
      while (m_fx != 300 && guard < 400) begin
         vs_pulse();
         rnd_pix(1'b1);
         guard++;
      end
      chk("reach_fx300", m_fx, 300);

      // Clipping at the right edge and the virtual wrap on the left
      drive(638, 140, 1'b1, 1'b1, 1'b1);
      drive(639, 141, 1'b1, 1'b1, 1'b1);
      drive(600, 150, 1'b1, 1'b1, 1'b1);
      for (int s = 0; s < 44; s++) drive(s * 2, 140, 1'b1, 1'b1, 1'b1);

      // Blanking with random syncs
      for (int i = 0; i < 40; i++)
         drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
               1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive(0, 0, 1'b0, 1'b1, 1'b1);

      // Mid-line reset
      repeat (10) rnd_pix(1'b1);
      do_reset(3);
      drive(10, 130, 1'b1, 1'b1, 1'b1);
      repeat (50) rnd_pix(1'b1);
      for (int i = 0; i < 6; i++) begin
         vs_pulse();
         repeat (3) rnd_pix(1'b1);
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
